systolic_ws_array: RTL
======================

Name: systolic_ws_array

Overview:
- Parametrised N x N weight-stationary systolic matrix unit.
- Computes out = A x W for a stream of M input row vectors against a stationary N x N weight matrix W.
- Adds what the fixed 4x4 version lacks:
  - internal input skew and output deskew, so callers present and receive unskewed vectors;
  - a sequencing FSM;
  - valid/ready input handshake;
  - a weight-reuse mode;
  - optional saturating accumulation.
- Sits between the image line buffer and the brightness post-processing stage.

Parameters:
- DEPTH, 4, array dimension N (rows = columns = N), 2..16.
- BIT_WIDTH, 16, signed width of data and weight elements.
- ACC_WIDTH, 40, signed accumulator/output element width; must be >= 2*BIT_WIDTH + clog2(DEPTH).
- SAT, 0, 1 = saturate accumulator at signed ACC_WIDTH limits; 0 = two's-complement wrap.
- ROWS_W, 16, width of the cfg_rows count.

Ports:
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle job start; sampled in IDLE only.
- reuse_w, in, 1, sampled with start; 1 = skip LOAD_W and keep current weights.
- cfg_rows, in, ROWS_W, number of input vectors M; sampled with start.
- wt_valid, in, 1, weight beat valid; accepted only in LOAD_W.
- wt_row, in, BIT_WIDTH*DEPTH, weight row W[k][*]; element j in bits [j*BW +: BW].
- in_valid, in, 1, input vector valid.
- in_ready, out, 1, unit accepts an input vector this cycle.
- in_row, in, BIT_WIDTH*DEPTH, input vector a[*]; element k in bits [k*BW +: BW].
- out_valid, out, 1, out_row holds a result vector.
- out_row, out, ACC_WIDTH*DEPTH, result r[j] = sum_k a[k]*W[k][j]; element j in bits [j*ACC +: ACC].
- busy, out, 1, FSM not in IDLE.
- done, out, 1, one-cycle pulse at job end.

Behaviour:
- Reset: asynchronous and active-low. All state clears: FSM = IDLE, weights = 0, pipeline, skew and valid registers = 0.
  - Output values in reset: in_ready = 0, out_valid = 0, out_row = 0, busy = 0, done = 0.
  - Reset mid-job aborts the job. No out_valid or done is produced for the aborted job.
- FSM states: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
  - IDLE:
    - start & !reuse_w -> LOAD_W.
    - start & reuse_w -> COMPUTE.
    - If cfg_rows = 0, start -> DONE directly, weights untouched.
  - LOAD_W:
    - Each wt_valid beat writes W[k] with k = beat index 0..N-1, addressed (not shifted).
    - After beat N-1: -> COMPUTE if cfg_rows != 0, else -> DONE.
    - No timeout; wt_valid gaps are allowed.
  - COMPUTE:
    - in_ready = 1 while the accepted count < cfg_rows.
    - A transfer occurs when in_valid & in_ready.
    - Gaps insert bubbles, which are tracked by a valid token.
    - After the M-th transfer: -> DRAIN, and in_ready drops in the same cycle.
  - DRAIN: waits until the M-th out_valid, then -> DONE.
  - DONE: done = 1 for one cycle, then -> IDLE.
  - start outside IDLE is ignored.
- Dataflow:
  - Element a[k] is delayed k cycles (row skew) and enters PE(k,0).
  - Data moves right one PE per cycle.
  - Partial sums move down one PE per cycle.
  - The column j bottom output is delayed N-1-j cycles (deskew).
- Latency: fixed at exactly 2*DEPTH cycles from the accepting clock edge to out_valid, independent of bubbles.
  - Successive results keep input order and spacing.
  - No output backpressure; out_valid is a pulse per vector.
- Arithmetic:
  - Products are signed BW x BW, sign-extended to ACC_WIDTH.
  - SAT = 1: each add clamps to [-2^(ACC-1), 2^(ACC-1)-1].
  - SAT = 0: each add wraps.
- out_row holds its last value when out_valid = 0; it is not cleared.
- Weights persist across jobs until a LOAD_W or reset.

Test Plan:
- Identity W, N=4, M=4, inputs [0,1,2,3], [4,5,6,7], [8,9,a,b], [c,d,e,f] -> out_row equals each input at accept+8 cycles; 4 consecutive out_valid pulses, then done one cycle later.
- W[k][j] = k+1 in all columns, input [1,1,1,1] -> every element = 10. Same job with reuse_w=1 -> no wt beats consumed, same result.
- in_valid toggling 1,0,1,0 -> out_valid pattern 1,0,1,0 shifted by exactly 8 cycles; values correct; in_ready drops after the 4th transfer.
- W all 0x7FFF, input all 0x7FFF:
  - SAT=0, ACC_WIDTH=32 -> 4*0x3FFF0001 wraps to 0xFFFC0004.
  - SAT=1, ACC_WIDTH=32 -> 0x7FFFFFFF.
  - Negative case (W = -1, input 0x8000): products are +0x8000 each, giving 0x00020000.
- cfg_rows=0 with start -> done at start+1, no out_valid; start while busy ignored.
- rst_n low during COMPUTE after 2 transfers -> all outputs 0 immediately; no out_valid afterwards; the next job with reuse_w=1 uses W = 0 -> outputs 0.

Source files
------------

// File: rtl/systolic_ws_array.sv
// systolic_ws_array
// -----------------------------------------------------------------------------
// Parametrised DEPTH x DEPTH weight-stationary systolic matrix unit. It computes
// r[j] = sum_k a[k] * W[k][j] for a stream of cfg_rows input vectors against a
// stationary weight matrix. Callers present unskewed vectors and receive
// unskewed results: the input skew and the output deskew are internal.
// Every accepted vector produces one result exactly 2*DEPTH cycles after its
// accepting clock edge.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     one-cycle job start, sampled in IDLE only
//   reuse_w   sampled with start; 1 = keep current weights and skip LOAD_W
//   cfg_rows  number of input vectors in the job, sampled with start
//   wt_valid  weight beat valid, accepted only in LOAD_W
//   wt_row    weight row W[k][*], element j in bits [j*BIT_WIDTH +: BIT_WIDTH]
//   in_valid  input vector valid
//   in_ready  unit accepts an input vector this cycle
//   in_row    input vector a[*], element k in bits [k*BIT_WIDTH +: BIT_WIDTH]
//   out_valid out_row holds a new result vector (one-cycle pulse per vector)
//   out_row   result vector, element j in bits [j*ACC_WIDTH +: ACC_WIDTH]
//   busy      sequencer is not in IDLE
//   done      one-cycle pulse at job end
// -----------------------------------------------------------------------------
module systolic_ws_array #(
    parameter int DEPTH     = 4,
    parameter int BIT_WIDTH = 16,
    parameter int ACC_WIDTH = 40,
    parameter int SAT       = 0,
    parameter int ROWS_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           reuse_w,
    input  logic [ROWS_W-1:0]              cfg_rows,
    input  logic                           wt_valid,
    input  logic [BIT_WIDTH*DEPTH-1:0]     wt_row,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BIT_WIDTH*DEPTH-1:0]     in_row,
    output logic                           out_valid,
    output logic [ACC_WIDTH*DEPTH-1:0]     out_row,
    output logic                           busy,
    output logic                           done
);

    localparam int WK_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_W  = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [WK_W-1:0]   LAST_K  = WK_W'(DEPTH - 1);
    localparam logic [WK_W-1:0]   ONE_K   = WK_W'(1);
    localparam logic [ROWS_W-1:0] ONE_ROW = ROWS_W'(1);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Signed BW x BW product, sign-extended to the accumulator width.
    function automatic logic signed [ACC_WIDTH-1:0] mul_ext(
        input logic signed [BIT_WIDTH-1:0] a,
        input logic signed [BIT_WIDTH-1:0] b
    );
        logic signed [2*BIT_WIDTH-1:0] p;
        p = a * b;
        return ACC_WIDTH'(p);
    endfunction

    // Accumulator add: wraps, or clamps to the signed limits when SAT is set.
    // Overflow shows up as disagreement between the two top bits of the
    // one-bit-wider sum.
    function automatic logic signed [ACC_WIDTH-1:0] acc_add(
        input logic signed [ACC_WIDTH-1:0] x,
        input logic signed [ACC_WIDTH-1:0] y
    );
        logic [ACC_WIDTH:0] s;
        logic signed [ACC_WIDTH-1:0] r;
        s = {x[ACC_WIDTH-1], x} + {y[ACC_WIDTH-1], y};
        if ((SAT != 0) && (s[ACC_WIDTH] != s[ACC_WIDTH-1])) begin
            r = s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            r = s[ACC_WIDTH-1:0];
        end
        return r;
    endfunction

    logic [2:0]              state_r;
    logic [2:0]              state_nxt;
    logic [ROWS_W-1:0]       rows_r;
    logic [ROWS_W-1:0]       acc_cnt_r;
    logic [ROWS_W-1:0]       out_cnt_r;
    logic [WK_W-1:0]         wt_cnt_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [ACC_WIDTH*DEPTH-1:0] out_row_r;
    logic                    accept_s;

    logic signed [BIT_WIDTH-1:0] w_r   [DEPTH][DEPTH];
    logic signed [BIT_WIDTH-1:0] a_r   [DEPTH][DEPTH-1];
    logic signed [ACC_WIDTH-1:0] ps_r  [DEPTH][DEPTH];
    logic signed [BIT_WIDTH-1:0] row_in_s  [DEPTH];
    logic signed [ACC_WIDTH-1:0] col_out_s [DEPTH];
    logic [2*DEPTH-1:0]          vld_r;

    assign accept_s  = in_valid & in_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_row   = out_row_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Sequencer next-state decode.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (cfg_rows == '0) begin
                        state_nxt = S_DONE;
                    end else if (reuse_w) begin
                        state_nxt = S_COMPUTE;
                    end else begin
                        state_nxt = S_LOAD_W;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOAD_W: begin
                if (wt_valid && (wt_cnt_r == LAST_K)) begin
                    state_nxt = (rows_r == '0) ? S_DONE : S_COMPUTE;
                end else begin
                    state_nxt = S_LOAD_W;
                end
            end
            S_COMPUTE: begin
                if (accept_s && (acc_cnt_r == rows_r - ONE_ROW)) begin
                    state_nxt = S_DRAIN;
                end else begin
                    state_nxt = S_COMPUTE;
                end
            end
            S_DRAIN: begin
                if (out_valid_r && (out_cnt_r == rows_r - ONE_ROW)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state, job counters, status outputs and weight storage.
    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            rows_r     <= '0;
            acc_cnt_r  <= '0;
            out_cnt_r  <= '0;
            wt_cnt_r   <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            in_ready_r <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    w_r[k][j] <= '0;
                end
            end
        end else begin
            state_r    <= state_nxt;
            busy_r     <= (state_nxt != S_IDLE);
            done_r     <= (state_nxt == S_DONE);
            in_ready_r <= (state_nxt == S_COMPUTE);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        rows_r    <= cfg_rows;
                        acc_cnt_r <= '0;
                        out_cnt_r <= '0;
                        wt_cnt_r  <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (wt_valid) begin
                        // Beats are addressed by index, not shifted in.
                        for (int j = 0; j < DEPTH; j++) begin
                            w_r[wt_cnt_r][j] <= wt_row[j*BIT_WIDTH +: BIT_WIDTH];
                        end
                        wt_cnt_r <= (wt_cnt_r == LAST_K) ? '0 : wt_cnt_r + ONE_K;
                    end
                end
                S_COMPUTE: begin
                    if (accept_s) begin
                        acc_cnt_r <= acc_cnt_r + ONE_ROW;
                    end
                    if (out_valid_r) begin
                        out_cnt_r <= out_cnt_r + ONE_ROW;
                    end
                end
                S_DRAIN: begin
                    if (out_valid_r) begin
                        out_cnt_r <= out_cnt_r + ONE_ROW;
                    end
                end
                default: begin
                    rows_r <= rows_r;
                end
            endcase
        end
    end

    genvar gk, gj;
    generate
        for (gk = 0; gk < DEPTH; gk++) begin : g_skew
            logic signed [BIT_WIDTH-1:0] sk_r [gk+1];

            // Input register plus gk delay stages: element gk trails element 0
            // by gk cycles. Bubbles enter as zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s <= gk; s++) begin
                        sk_r[s] <= '0;
                    end
                end else begin
                    sk_r[0] <= accept_s ? in_row[gk*BIT_WIDTH +: BIT_WIDTH] : '0;
                    for (int s = 1; s <= gk; s++) begin
                        sk_r[s] <= sk_r[s-1];
                    end
                end
            end

            assign row_in_s[gk] = sk_r[gk];
        end

        for (gk = 0; gk < DEPTH; gk++) begin : g_row
            for (gj = 0; gj < DEPTH; gj++) begin : g_col
                logic signed [BIT_WIDTH-1:0] a_in_s;
                logic signed [ACC_WIDTH-1:0] p_in_s;

                if (gj == 0) begin : g_a_edge
                    assign a_in_s = row_in_s[gk];
                end else begin : g_a_mid
                    assign a_in_s = a_r[gk][gj-1];
                end

                if (gk == 0) begin : g_p_edge
                    assign p_in_s = '0;
                end else begin : g_p_mid
                    assign p_in_s = ps_r[gk-1][gj];
                end

                // Processing element: partial sum moves down, data moves right.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ps_r[gk][gj] <= '0;
                    end else begin
                        ps_r[gk][gj] <= acc_add(p_in_s, mul_ext(a_in_s, w_r[gk][gj]));
                    end
                end

                if (gj < DEPTH - 1) begin : g_a_reg
                    // Data hand-off to the PE on the right.
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            a_r[gk][gj] <= '0;
                        end else begin
                            a_r[gk][gj] <= a_in_s;
                        end
                    end
                end
            end
        end

        for (gj = 0; gj < DEPTH; gj++) begin : g_dsk
            if (gj == DEPTH - 1) begin : g_nodly
                assign col_out_s[gj] = ps_r[DEPTH-1][gj];
            end else begin : g_dly
                logic signed [ACC_WIDTH-1:0] ds_r [DEPTH-1-gj];

                // Column gj leaves the array gj cycles after column 0; delay it
                // by DEPTH-1-gj so all columns of a vector align.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int s = 0; s < DEPTH - 1 - gj; s++) begin
                            ds_r[s] <= '0;
                        end
                    end else begin
                        ds_r[0] <= ps_r[DEPTH-1][gj];
                        for (int s = 1; s < DEPTH - 1 - gj; s++) begin
                            ds_r[s] <= ds_r[s-1];
                        end
                    end
                end

                assign col_out_s[gj] = ds_r[DEPTH-2-gj];
            end
        end
    endgenerate

    // Valid token pipeline and output register; out_row holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r       <= '0;
            out_valid_r <= 1'b0;
            out_row_r   <= '0;
        end else begin
            vld_r       <= {vld_r[2*DEPTH-2:0], accept_s};
            out_valid_r <= vld_r[2*DEPTH-1];
            if (vld_r[2*DEPTH-1]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    out_row_r[j*ACC_WIDTH +: ACC_WIDTH] <= col_out_s[j];
                end
            end else begin
                out_row_r <= out_row_r;
            end
        end
    end

endmodule
